// File: rtl/gf16_sqrt_iter.sv
// gf16_sqrt_iter: sequential GF(2^4) square-root / square engine.
// Field polynomial x^4 + x + 1. The engine works on LANES independent nibbles.
// sqrt(a) = a^8 is formed by three squarings (one per clock); square is a
// single squaring. Valid/ready handshakes are used on both the input and the
// output side.
module gf16_sqrt_iter #(
    parameter int unsigned LANES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_op,
    input  logic [4*LANES-1:0]   in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*LANES-1:0]   out_data,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    state_t               next_state;
    logic [4*LANES-1:0]   acc;
    logic [4*LANES-1:0]   acc_sq;
    logic [1:0]           cnt;
    logic                 accept;
    logic                 last_step;

    // Squaring of one nibble: x^4 = x + 1 folds a2 and a3 back into the low terms.
    function automatic logic [3:0] sq_nib(input logic [3:0] a);
        logic [3:0] b;
        b[3] = a[3];
        b[2] = a[1] ^ a[3];
        b[1] = a[2];
        b[0] = a[0] ^ a[2];
        return b;
    endfunction

    // Lane-parallel squaring; lanes never interact.
    function automatic logic [4*LANES-1:0] sq_word(input logic [4*LANES-1:0] w);
        logic [4*LANES-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            r[4*i +: 4] = sq_nib(w[4*i +: 4]);
        end
        return r;
    endfunction

    // Squared version of the accumulator, used on every RUN cycle.
    always_comb begin
        acc_sq = sq_word(acc);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        accept     = 1'b0;
        last_step  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == 2'd1) begin
                    last_step  = 1'b1;
                    next_state = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath: load on accept, square once per RUN cycle, and capture the
    // final squaring into out_data so the result is held through DONE and
    // retained after the handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            cnt      <= '0;
            out_data <= '0;
        end else if (accept) begin
            acc <= in_data;
            cnt <= in_op ? 2'd1 : 2'd3;
        end else if (state == RUN) begin
            acc <= acc_sq;
            cnt <= cnt - 2'd1;
            if (last_step) begin
                out_data <= acc_sq;
            end
        end
    end

endmodule
